// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC/flush from PC control, instruction memory read port,
// and the instruction register handshake toward decode.
interface instr_fetch_if;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_advance;
  logic        fault;

  modport master (
    input  pc, flush, mem_rdata, mem_ready, ir_ready,
    output mem_addr, mem_req, ir, ir_pc, ir_valid, pc_advance, fault
  );

  modport slave (
    output pc, flush, mem_rdata, mem_ready, ir_ready,
    input  mem_addr, mem_req, ir, ir_pc, ir_valid, pc_advance, fault
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples PC, runs one req/ready memory read, holds the
// word for decode and pulses pc_advance once per completed fetch.
module instr_fetch #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter logic [7:0]  MAX_WAIT = 8'd15
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master fe
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        pc_advance_q, pc_advance_d;
  logic        fault_q, fault_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;
  logic        flush_act;
  logic        mem_done;
  logic        timeout;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign wait_inc  = sat_inc8(wait_q);
  assign flush_act = fe.flush && (state_q != S_FAULT);
  assign mem_done  = mem_req_q && fe.mem_ready;
  assign timeout   = (MAX_WAIT != 8'd0) && (wait_inc == MAX_WAIT);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything except a latched fault
  always_comb begin
    state_d = state_q;
    if (flush_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fe.pc[1:0] != 2'b00) state_d = S_FAULT;
          else                     state_d = S_FETCH;
        end
        S_FETCH: begin
          if (mem_done)     state_d = S_HOLD;
          else if (timeout) state_d = S_FAULT;
        end
        S_HOLD: begin
          if (ir_valid_q && fe.ir_ready) state_d = S_IDLE;
        end
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Output next-values, derived from the transition being taken
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    pc_advance_d = 1'b0;
    fault_d      = fault_q;
    wait_d       = wait_q;

    if (flush_act) begin
      mem_req_d  = 1'b0;
      ir_valid_d = 1'b0;
      ir_d       = NOP_WORD;
      wait_d     = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_d == S_FETCH) begin
            mem_addr_d = fe.pc;
            mem_req_d  = 1'b1;
            wait_d     = 8'd0;
          end
        end
        S_FETCH: begin
          if (state_d == S_HOLD) begin
            ir_d         = fe.mem_rdata;
            ir_pc_d      = mem_addr_q;
            ir_valid_d   = 1'b1;
            mem_req_d    = 1'b0;
            pc_advance_d = 1'b1;
          end else begin
            wait_d = wait_inc;
          end
        end
        S_HOLD: begin
          if (state_d == S_IDLE) ir_valid_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Fault entry and residence both force the safe output set
    if (state_d == S_FAULT) begin
      fault_d      = 1'b1;
      mem_req_d    = 1'b0;
      ir_valid_d   = 1'b0;
      ir_d         = NOP_WORD;
      pc_advance_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr_q   <= 32'd0;
      mem_req_q    <= 1'b0;
      ir_q         <= NOP_WORD;
      ir_pc_q      <= 32'd0;
      ir_valid_q   <= 1'b0;
      pc_advance_q <= 1'b0;
      fault_q      <= 1'b0;
      wait_q       <= 8'd0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      pc_advance_q <= pc_advance_d;
      fault_q      <= fault_d;
      wait_q       <= wait_d;
    end
  end

  assign fe.mem_addr   = mem_addr_q;
  assign fe.mem_req    = mem_req_q;
  assign fe.ir         = ir_q;
  assign fe.ir_pc      = ir_pc_q;
  assign fe.ir_valid   = ir_valid_q;
  assign fe.pc_advance = pc_advance_q;
  assign fe.fault      = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instr_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          MAXW = 15;

  logic clk;
  logic reset;
  instr_fetch_if fe();

  instr_fetch #(.NOP_WORD(NOP), .MAX_WAIT(8'd15)) dut (
    .clock (clk),
    .reset (reset),
    .fe    (fe)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int adv_cnt     = 0;
  bit chk_en      = 0;

  // Reference model state: the phase is implied by which outputs are live
  logic [31:0] m_addr, m_ir, m_irpc;
  logic        m_req, m_valid, m_adv, m_fault;
  int          m_wait;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_fault();
    m_fault = 1; m_req = 0; m_valid = 0; m_ir = NOP; m_adv = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_addr = 0; m_ir = NOP; m_irpc = 0;
      m_valid = 0; m_adv = 0; m_fault = 0; m_wait = 0;
    end else if (!m_fault) begin
      m_adv = 0;
      if (fe.flush) begin
        m_req = 0; m_valid = 0; m_ir = NOP; m_wait = 0;
      end else if (m_req) begin
        if (fe.mem_ready) begin
          m_ir = fe.mem_rdata; m_irpc = m_addr; m_valid = 1; m_req = 0; m_adv = 1;
        end else begin
          if (m_wait < 255) m_wait++;
          if (MAXW != 0 && m_wait == MAXW) model_fault();
        end
      end else if (m_valid) begin
        if (fe.ir_ready) m_valid = 0;
      end else if (fe.pc[1:0] != 2'b00) begin
        model_fault();
      end else begin
        m_addr = fe.pc; m_req = 1; m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_mem_addr",   fe.mem_addr,   m_addr);
      chk("cyc_mem_req",    32'(fe.mem_req),    32'(m_req));
      chk("cyc_ir",         fe.ir,         m_ir);
      chk("cyc_ir_pc",      fe.ir_pc,      m_irpc);
      chk("cyc_ir_valid",   32'(fe.ir_valid),   32'(m_valid));
      chk("cyc_pc_advance", 32'(fe.pc_advance), 32'(m_adv));
      chk("cyc_fault",      32'(fe.fault),      32'(m_fault));
      adv_cnt += int'(fe.pc_advance);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] pc_v, input logic ir_rdy);
    reset = 1;
    fe.pc = pc_v; fe.flush = 0; fe.mem_ready = 0; fe.mem_rdata = 0; fe.ir_ready = ir_rdy;
    step(1);
    reset = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req"},   32'(fe.mem_req), 0);
    chk({tag, "_addr"},  fe.mem_addr, 0);
    chk({tag, "_ir"},    fe.ir, NOP);
    chk({tag, "_irpc"},  fe.ir_pc, 0);
    chk({tag, "_valid"}, 32'(fe.ir_valid), 0);
    chk({tag, "_adv"},   32'(fe.pc_advance), 0);
    chk({tag, "_fault"}, 32'(fe.fault), 0);
  endtask

  int a0;

  initial begin
    clk = 0; reset = 1;
    fe.pc = 0; fe.flush = 0; fe.mem_rdata = 0; fe.mem_ready = 0; fe.ir_ready = 0;
    step(2);
    chk_en = 1;

    // 1: basic fetch, memory answers two cycles after request
    do_reset(32'h100, 1'b1);
    reset_checks("s1_rst");
    step(1);
    chk("s1_req", 32'(fe.mem_req), 1);
    chk("s1_addr", fe.mem_addr, 32'h100);
    a0 = adv_cnt;
    step(1);
    fe.mem_ready = 1; fe.mem_rdata = 32'hDEAD_BEEF;
    step(1);
    chk("s1_ir", fe.ir, 32'hDEAD_BEEF);
    chk("s1_ir_pc", fe.ir_pc, 32'h100);
    chk("s1_valid", 32'(fe.ir_valid), 1);
    chk("s1_adv", 32'(fe.pc_advance), 1);
    chk("s1_req_low", 32'(fe.mem_req), 0);
    fe.mem_ready = 0; fe.pc = 32'h104;
    step(1);
    chk("s1_valid_1cyc", 32'(fe.ir_valid), 0);
    chk("s1_ir_kept", fe.ir, 32'hDEAD_BEEF);
    chk("s1_pulses", 32'(adv_cnt - a0), 1);
    chk("s1_model_ir", m_ir, 32'hDEAD_BEEF);

    // 2: decode stalls for five cycles in HOLD
    do_reset(32'h100, 1'b0);
    step(1);
    fe.mem_ready = 1; fe.mem_rdata = 32'hCAFE_F00D;
    step(1);
    fe.mem_ready = 0; fe.pc = 32'h104;
    a0 = adv_cnt;
    step(5);
    chk("s2_valid", 32'(fe.ir_valid), 1);
    chk("s2_ir", fe.ir, 32'hCAFE_F00D);
    chk("s2_req", 32'(fe.mem_req), 0);
    chk("s2_no_pulse", 32'(fe.pc_advance), 0);
    fe.ir_ready = 1;
    step(1);
    chk("s2_valid_fall", 32'(fe.ir_valid), 0);
    step(1);
    chk("s2_req_next", 32'(fe.mem_req), 1);
    chk("s2_addr_next", fe.mem_addr, 32'h104);
    chk("s2_pulses", 32'(adv_cnt - a0), 1);

    // 3: flush coincides with mem_ready; stale ready afterwards
    do_reset(32'h100, 1'b1);
    step(1);
    a0 = adv_cnt;
    fe.mem_ready = 1; fe.mem_rdata = 32'h1234_5678; fe.flush = 1;
    step(1);
    chk("s3_ir", fe.ir, NOP);
    chk("s3_valid", 32'(fe.ir_valid), 0);
    chk("s3_adv", 32'(fe.pc_advance), 0);
    chk("s3_req", 32'(fe.mem_req), 0);
    fe.flush = 0; fe.pc = 32'h200;
    step(1);
    chk("s3_req2", 32'(fe.mem_req), 1);
    chk("s3_addr2", fe.mem_addr, 32'h200);
    chk("s3_no_pulse", 32'(adv_cnt - a0), 0);
    fe.mem_ready = 0;
    step(1);
    fe.mem_ready = 1; fe.mem_rdata = 32'h0BAD_C0DE;
    step(1);
    chk("s3_ir2", fe.ir, 32'h0BAD_C0DE);
    chk("s3_ir_pc2", fe.ir_pc, 32'h200);
    fe.mem_ready = 0;
    step(1);

    // 4: misaligned PC
    do_reset(32'h102, 1'b1);
    step(1);
    chk("s4_fault", 32'(fe.fault), 1);
    chk("s4_req", 32'(fe.mem_req), 0);
    step(3);
    chk("s4_fault_sticky", 32'(fe.fault), 1);
    reset = 1;
    step(1);
    chk("s4_fault_clr", 32'(fe.fault), 0);
    reset = 0; fe.pc = 32'h0;
    step(1);

    // 5: memory never answers -> timeout after MAX_WAIT fetch cycles
    do_reset(32'h300, 1'b1);
    step(15);
    chk("s5_no_fault_yet", 32'(fe.fault), 0);
    chk("s5_req_held", 32'(fe.mem_req), 1);
    step(1);
    chk("s5_fault", 32'(fe.fault), 1);
    chk("s5_req", 32'(fe.mem_req), 0);
    fe.flush = 1; fe.mem_ready = 1;
    step(2);
    chk("s5_flush_ign", 32'(fe.fault), 1);
    chk("s5_req_after", 32'(fe.mem_req), 0);
    fe.flush = 0; fe.mem_ready = 0;

    // 6: reset during FETCH and during HOLD
    do_reset(32'h400, 1'b0);
    step(1);
    reset = 1;
    step(1);
    reset_checks("s6_fetch");
    reset = 0;
    step(1);
    fe.mem_ready = 1; fe.mem_rdata = 32'h5555_AAAA;
    step(1);
    fe.mem_ready = 0;
    reset = 1;
    step(1);
    reset_checks("s6_hold");
    reset = 0;

    // 7: streaming with varying memory latency and decode stalls
    do_reset(32'h1000, 1'b1);
    a0 = adv_cnt;
    for (int c = 0; c < 60; c++) begin
      fe.mem_ready = fe.mem_req && ((c % 3) != 0);
      fe.mem_rdata = fe.mem_addr ^ 32'hA5A5_0000;
      fe.ir_ready  = ((c % 4) != 1);
      if (fe.pc_advance) fe.pc = fe.pc + 32'd4;
      step(1);
    end
    chk("s7_progress", 32'(adv_cnt - a0 > 5), 1);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
